id_ex_hazard_stage: RTL and testbench
=====================================

# id_ex_hazard_stage

ID/EX pipeline register combined with load-use hazard detection and branch-flush control for the 5-stage RISC-V core. It sits between decode and execute. It registers decoded operands and controls into the ID_EX_* signals consumed by execute and by the forwarding logic. It stalls PC and IF/ID, injects bubbles on load-use hazards, squashes on taken branches, and counts stall and flush events.

## Interface
- Parameters:
  - CNT_W, default 32: width of the stall and flush event counters.
- Ports:
  - clk  in  1  core clock.
  - rst  in  1  reset; synchronous, active-high.
  - IF_ID_Valid  in  1  decode holds a real instruction.
  - IF_ID_PC  in  32  PC of the decoded instruction.
  - IF_ID_RS1, IF_ID_RS2, IF_ID_RDes  in  5 each  register indices.
  - IF_ID_INSTR_TYPE  in  3  instruction type: 000 R, 001 I, 010 S, 011 B, 100 JALR, 101 J, 110 U.
  - IF_ID_RS1_Data, IF_ID_RS2_Data, IF_ID_Imm  in  32 each  register-file read data and immediate.
  - IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_Branch  in  1 each  decoded controls.
  - IF_ID_ALUOp  in  4  ALU operation.
  - Branch_Taken  in  1  execute resolved a taken branch or jump this cycle.
  - Ext_Stall  in  1  memory-side freeze of the whole front end.
  - ID_EX_*  out  same widths as the IF_ID_* inputs  registered copies: Valid, PC, RS1, RS2, RDes, INSTR_TYPE, RS1_Data, RS2_Data, Imm, RegWrite, MemRead, MemWrite, Branch, ALUOp.
  - Stall_PC, Stall_IF_ID  out  1 each  hold PC and the IF/ID register.
  - Flush_IF_ID  out  1  squash the IF/ID register.
  - Hz_State  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
  - Stall_Count, Flush_Count  out  CNT_W each  event counters.

## Operation
- Operand use:
  - RS1 is used unless the type is U or J.
  - RS2 is used only for R, S and B.
- Load-use hazard (LU) requires all of:
  - ID_EX_MemRead and ID_EX_RDes != 0.
  - IF_ID_Valid.
  - ID_EX_RDes matches a used source register of the decoded instruction.
- Store exemption: when the type is S and only RS2 matches, LU is not raised. Store data is supplied by the MEM-stage load→store forward.
- Priority, evaluated each cycle:
  1. Ext_Stall: every register holds. Stall_PC = Stall_IF_ID = 1, Flush_IF_ID = 0. Counters and FSM hold. A pending Branch_Taken is ignored here; execute is frozen too, so it is re-presented later.
  2. Branch_Taken: ID/EX loads a bubble. Flush_IF_ID = 1, Stall_* = 0. Flush_Count++. Next state is FLUSH.
  3. LU: ID/EX loads a bubble. Stall_PC = Stall_IF_ID = 1. Stall_Count++. Next state is STALL.
  4. Otherwise ID/EX loads the IF_ID_* inputs. Next state is RUN.
- A bubble sets Valid, RegWrite, MemRead, MemWrite and Branch to 0, and RDes, RS1, RS2, Imm, data, PC, INSTR_TYPE and ALUOp to 0.
- FSM:
  - RUN and FLUSH leave according to the priority above.
  - STALL is held at most one cycle. After the bubble, ID_EX_MemRead is 0, so LU cannot re-fire on the same pair.
  - If LU is evaluated true in STALL, that is a design error; the bench asserts it never happens.
- Counters wrap modulo 2^CNT_W.

## Timing
- Stall_PC, Stall_IF_ID and Flush_IF_ID are combinational from the current ID_EX_* registers and the current inputs, in the same cycle.
- ID_EX_* and Hz_State update at the rising edge of clk; latency is 1 cycle.
- A load followed by a dependent use costs exactly 1 bubble. The use then reaches EX while the load is in WB, and is satisfied by WB forwarding.
- Reset: every ID_EX_* output is 0 (a bubble), Hz_State = RUN, both counters 0, and Stall_* and Flush_IF_ID are 0.
- Reset asserted mid-stall or mid-flush discards the pending action. Counters are not incremented in that cycle.
- Branch_Taken and LU in the same cycle: the flush wins and only Flush_Count increments. The stalled younger instruction is squashed anyway.

## Structure
- A shared package holds:
  - INSTR_TYPE encodings (R, I, S, B, JALR, J, U).
  - Hz_State encodings.
  - The bubble constant and the use-RS1/use-RS2 decode functions.
- One sub-module, lu_hazard_detect, is purely combinational. It produces LU from the ID_EX load fields and the IF_ID source fields. The register, FSM and counters stay in the top module.

## Test plan
- **Load-use on RS1:** lw x5 in ID/EX, add x6,x5,x1 in decode → Stall_PC = Stall_IF_ID = 1 for 1 cycle, a bubble in ID/EX (RegWrite = 0), Stall_Count = 1, then the add enters ID/EX.
- **Store exemption:** lw x5 followed by sw x5,0(x2) → no stall. With sw x7,0(x5) instead → 1-cycle stall.
- **x0 and U/J ignored:** lw x0 followed by add x1,x0,x0 → no stall. lw x5 followed by lui x5 → no stall.
- **Branch beats load-use:** Branch_Taken together with LU → Flush_IF_ID = 1, bubble, Flush_Count = 1, Stall_Count unchanged, Hz_State = FLUSH.
- **Ext_Stall priority:** Ext_Stall held 3 cycles with LU present → ID_EX_* unchanged, counters unchanged. The stall and bubble occur on the first cycle after release.
- **Reset during STALL:** rst asserted → all outputs 0, Hz_State = RUN, counters 0 on the next edge.

Source files
------------

// File: rtl/id_ex_hazard_stage_pkg.sv
// id_ex_hazard_stage_pkg: shared encodings, ID/EX payload type and operand-use decode
// Contents: instr_type_e, hz_state_e, id_ex_t payload, BUBBLE constant, use_rs1/use_rs2
package id_ex_hazard_stage_pkg;
   typedef enum logic [2:0] {IT_R = 3'b000, IT_I, IT_S, IT_B, IT_JALR, IT_J, IT_U} instr_type_e;
   typedef enum logic [1:0] {HZ_RUN = 2'b00, HZ_STALL = 2'b01, HZ_FLUSH = 2'b10} hz_state_e;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rdes;
      logic [2:0]  itype;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic [3:0]  alu_op;
   } id_ex_t;
   localparam id_ex_t BUBBLE = '0;
   function automatic logic use_rs1(input logic [2:0] t);
      return !(t == IT_U || t == IT_J);
   endfunction
   function automatic logic use_rs2(input logic [2:0] t);
      return t == IT_R || t == IT_S || t == IT_B;
   endfunction
endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// id_ex_hazard_stage_if: decode-side inputs, ID/EX outputs and hazard controls of the stage
// master: drives IF_ID_*, Branch_Taken, Ext_Stall; slave: drives ID_EX_*, Stall_*, Flush_IF_ID, Hz_State, counters
interface id_ex_hazard_stage_if #(parameter int CNT_W = 32);
   logic             IF_ID_Valid, IF_ID_RegWrite, IF_ID_MemRead, IF_ID_MemWrite, IF_ID_Branch;
   logic [31:0]      IF_ID_PC, IF_ID_RS1_Data, IF_ID_RS2_Data, IF_ID_Imm;
   logic [4:0]       IF_ID_RS1, IF_ID_RS2, IF_ID_RDes;
   logic [2:0]       IF_ID_INSTR_TYPE;
   logic [3:0]       IF_ID_ALUOp;
   logic             Branch_Taken, Ext_Stall;
   logic             ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch;
   logic [31:0]      ID_EX_PC, ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm;
   logic [4:0]       ID_EX_RS1, ID_EX_RS2, ID_EX_RDes;
   logic [2:0]       ID_EX_INSTR_TYPE;
   logic [3:0]       ID_EX_ALUOp;
   logic             Stall_PC, Stall_IF_ID, Flush_IF_ID;
   logic [1:0]       Hz_State;
   logic [CNT_W-1:0] Stall_Count, Flush_Count;
   modport master (
      output IF_ID_Valid, IF_ID_PC, IF_ID_RS1, IF_ID_RS2, IF_ID_RDes, IF_ID_INSTR_TYPE,
             IF_ID_RS1_Data, IF_ID_RS2_Data, IF_ID_Imm, IF_ID_RegWrite, IF_ID_MemRead,
             IF_ID_MemWrite, IF_ID_Branch, IF_ID_ALUOp, Branch_Taken, Ext_Stall,
      input  ID_EX_Valid, ID_EX_PC, ID_EX_RS1, ID_EX_RS2, ID_EX_RDes, ID_EX_INSTR_TYPE,
             ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm, ID_EX_RegWrite, ID_EX_MemRead,
             ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp, Stall_PC, Stall_IF_ID, Flush_IF_ID,
             Hz_State, Stall_Count, Flush_Count
   );
   modport slave (
      input  IF_ID_Valid, IF_ID_PC, IF_ID_RS1, IF_ID_RS2, IF_ID_RDes, IF_ID_INSTR_TYPE,
             IF_ID_RS1_Data, IF_ID_RS2_Data, IF_ID_Imm, IF_ID_RegWrite, IF_ID_MemRead,
             IF_ID_MemWrite, IF_ID_Branch, IF_ID_ALUOp, Branch_Taken, Ext_Stall,
      output ID_EX_Valid, ID_EX_PC, ID_EX_RS1, ID_EX_RS2, ID_EX_RDes, ID_EX_INSTR_TYPE,
             ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm, ID_EX_RegWrite, ID_EX_MemRead,
             ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp, Stall_PC, Stall_IF_ID, Flush_IF_ID,
             Hz_State, Stall_Count, Flush_Count
   );
endinterface

// File: rtl/id_ex_hazard_stage_lu_hazard_detect.sv
// lu_hazard_detect: combinational load-use hazard between the load in ID/EX and the decoded instruction
// in: id_ex_mem_read_i, id_ex_rdes_i, if_id_valid_i, if_id_rs1_i, if_id_rs2_i, if_id_type_i; out: lu_o
module lu_hazard_detect
   import id_ex_hazard_stage_pkg::*;
(
   input  logic       id_ex_mem_read_i,
   input  logic [4:0] id_ex_rdes_i,
   input  logic       if_id_valid_i,
   input  logic [4:0] if_id_rs1_i,
   input  logic [4:0] if_id_rs2_i,
   input  logic [2:0] if_id_type_i,
   output logic       lu_o
);
   logic hit1, hit2;
   assign hit1 = use_rs1(if_id_type_i) && if_id_rs1_i == id_ex_rdes_i;
   // store data comes from the MEM-stage load->store forward, so a store's rs2 never stalls
   assign hit2 = use_rs2(if_id_type_i) && if_id_type_i != IT_S && if_id_rs2_i == id_ex_rdes_i;
   assign lu_o = id_ex_mem_read_i && id_ex_rdes_i != 5'd0 && if_id_valid_i && (hit1 || hit2);
endmodule

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX register with load-use stall, branch flush, hazard FSM and event counters
// in: clk, rst, bus.IF_ID_*, bus.Branch_Taken, bus.Ext_Stall
// out: bus.ID_EX_*, bus.Stall_PC, bus.Stall_IF_ID, bus.Flush_IF_ID, bus.Hz_State, bus.Stall_Count, bus.Flush_Count
module id_ex_hazard_stage #(parameter int CNT_W = 32) (
   input logic                 clk,
   input logic                 rst,
   id_ex_hazard_stage_if.slave bus
);
   import id_ex_hazard_stage_pkg::*;
   id_ex_t           if_id, id_ex_q, id_ex_d;
   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             lu, stall;
   assign if_id = '{valid: bus.IF_ID_Valid, pc: bus.IF_ID_PC, rs1: bus.IF_ID_RS1, rs2: bus.IF_ID_RS2,
                    rdes: bus.IF_ID_RDes, itype: bus.IF_ID_INSTR_TYPE, rs1_data: bus.IF_ID_RS1_Data,
                    rs2_data: bus.IF_ID_RS2_Data, imm: bus.IF_ID_Imm, reg_write: bus.IF_ID_RegWrite,
                    mem_read: bus.IF_ID_MemRead, mem_write: bus.IF_ID_MemWrite, branch: bus.IF_ID_Branch,
                    alu_op: bus.IF_ID_ALUOp};
   lu_hazard_detect u_lu (
      .id_ex_mem_read_i (id_ex_q.mem_read),
      .id_ex_rdes_i     (id_ex_q.rdes),
      .if_id_valid_i    (bus.IF_ID_Valid),
      .if_id_rs1_i      (bus.IF_ID_RS1),
      .if_id_rs2_i      (bus.IF_ID_RS2),
      .if_id_type_i     (bus.IF_ID_INSTR_TYPE),
      .lu_o             (lu)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HZ_RUN;
         id_ex_q     <= BUBBLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         id_ex_q     <= id_ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end
   // Ext_Stall freezes everything; a taken branch outranks the load-use stall
   always_comb begin
      state_d     = bus.Ext_Stall ? state_q : bus.Branch_Taken ? HZ_FLUSH : lu ? HZ_STALL : HZ_RUN;
      id_ex_d     = bus.Ext_Stall ? id_ex_q : (bus.Branch_Taken || lu) ? BUBBLE : if_id;
      stall_cnt_d = stall_cnt_q + CNT_W'(!bus.Ext_Stall && !bus.Branch_Taken && lu);
      flush_cnt_d = flush_cnt_q + CNT_W'(!bus.Ext_Stall && bus.Branch_Taken);
   end
   always_comb begin
      stall           = bus.Ext_Stall || (!bus.Branch_Taken && lu);
      bus.Stall_PC    = stall;
      bus.Stall_IF_ID = stall;
      bus.Flush_IF_ID = !bus.Ext_Stall && bus.Branch_Taken;
   end
   assign bus.ID_EX_Valid      = id_ex_q.valid;
   assign bus.ID_EX_PC         = id_ex_q.pc;
   assign bus.ID_EX_RS1        = id_ex_q.rs1;
   assign bus.ID_EX_RS2        = id_ex_q.rs2;
   assign bus.ID_EX_RDes       = id_ex_q.rdes;
   assign bus.ID_EX_INSTR_TYPE = id_ex_q.itype;
   assign bus.ID_EX_RS1_Data   = id_ex_q.rs1_data;
   assign bus.ID_EX_RS2_Data   = id_ex_q.rs2_data;
   assign bus.ID_EX_Imm        = id_ex_q.imm;
   assign bus.ID_EX_RegWrite   = id_ex_q.reg_write;
   assign bus.ID_EX_MemRead    = id_ex_q.mem_read;
   assign bus.ID_EX_MemWrite   = id_ex_q.mem_write;
   assign bus.ID_EX_Branch     = id_ex_q.branch;
   assign bus.ID_EX_ALUOp      = id_ex_q.alu_op;
   assign bus.Hz_State         = state_q;
   assign bus.Stall_Count      = stall_cnt_q;
   assign bus.Flush_Count      = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// tb_id_ex_hazard_stage: directed stimulus with a per-cycle reference model and literal spot checks
module tb_id_ex_hazard_stage;
   logic clk = 0;
   logic rst = 1;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 0;
   id_ex_hazard_stage_if #(.CNT_W(32)) bus ();
   id_ex_hazard_stage #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // flat 155-bit view: valid,pc,rs1,rs2,rd,type,d1,d2,imm,rw,mr,mw,br,alu
   logic [154:0] m_ex = '0;
   logic [1:0]   m_st = 0;
   logic [31:0]  m_sc = 0, m_fc = 0;
   function automatic logic [154:0] in_vec();
      return {bus.IF_ID_Valid, bus.IF_ID_PC, bus.IF_ID_RS1, bus.IF_ID_RS2, bus.IF_ID_RDes,
              bus.IF_ID_INSTR_TYPE, bus.IF_ID_RS1_Data, bus.IF_ID_RS2_Data, bus.IF_ID_Imm,
              bus.IF_ID_RegWrite, bus.IF_ID_MemRead, bus.IF_ID_MemWrite, bus.IF_ID_Branch, bus.IF_ID_ALUOp};
   endfunction
   function automatic logic [154:0] out_vec();
      return {bus.ID_EX_Valid, bus.ID_EX_PC, bus.ID_EX_RS1, bus.ID_EX_RS2, bus.ID_EX_RDes,
              bus.ID_EX_INSTR_TYPE, bus.ID_EX_RS1_Data, bus.ID_EX_RS2_Data, bus.ID_EX_Imm,
              bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite, bus.ID_EX_Branch, bus.ID_EX_ALUOp};
   endfunction
   // load in model ID/EX whose destination the decoded instruction reads (store data exempt)
   function automatic logic model_lu();
      logic [4:0] rd;
      logic [2:0] t;
      logic       src1, src2;
      rd   = m_ex[111:107];
      t    = bus.IF_ID_INSTR_TYPE;
      src1 = t != 3'd5 && t != 3'd6 && bus.IF_ID_RS1 == rd;
      src2 = (t == 3'd0 || t == 3'd3) && bus.IF_ID_RS2 == rd;
      return m_ex[6] && rd != 5'd0 && bus.IF_ID_Valid && (src1 || src2);
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         m_ex <= '0;
         m_st <= 2'd0;
         m_sc <= 0;
         m_fc <= 0;
      end else if (!bus.Ext_Stall) begin
         if (bus.Branch_Taken) begin
            m_ex <= '0;
            m_st <= 2'd2;
            m_fc <= m_fc + 1;
         end else if (model_lu()) begin
            m_ex <= '0;
            m_st <= 2'd1;
            m_sc <= m_sc + 1;
         end else begin
            m_ex <= in_vec();
            m_st <= 2'd0;
         end
      end
   end
   task automatic chk(input string n, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask
   always @(negedge clk) if (chk_en) begin
      chk("id_ex", 160'(out_vec()), 160'(m_ex));
      chk("hz_state", 160'(bus.Hz_State), 160'(m_st));
      chk("stall_count", 160'(bus.Stall_Count), 160'(m_sc));
      chk("flush_count", 160'(bus.Flush_Count), 160'(m_fc));
      if (!rst) begin
         chk("stall_pc", 160'(bus.Stall_PC), 160'(bus.Ext_Stall || (!bus.Branch_Taken && model_lu())));
         chk("stall_if_id", 160'(bus.Stall_IF_ID), 160'(bus.Ext_Stall || (!bus.Branch_Taken && model_lu())));
         chk("flush_if_id", 160'(bus.Flush_IF_ID), 160'(!bus.Ext_Stall && bus.Branch_Taken));
         if (bus.Hz_State == 2'b01)
            chk("lu_in_stall", 160'(bus.Stall_PC && !bus.Ext_Stall), 160'(0));
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [2:0] t, input logic mr);
      bus.IF_ID_Valid      = v;
      bus.IF_ID_PC         = pc;
      bus.IF_ID_RS1        = rs1;
      bus.IF_ID_RS2        = rs2;
      bus.IF_ID_RDes       = rd;
      bus.IF_ID_INSTR_TYPE = t;
      bus.IF_ID_RS1_Data   = pc ^ 32'hA5A5_0000;
      bus.IF_ID_RS2_Data   = ~pc;
      bus.IF_ID_Imm        = pc + 32'd4;
      bus.IF_ID_RegWrite   = v && t != 3'd2 && t != 3'd3;
      bus.IF_ID_MemRead    = mr;
      bus.IF_ID_MemWrite   = t == 3'd2;
      bus.IF_ID_Branch     = t == 3'd3;
      bus.IF_ID_ALUOp      = pc[3:0];
   endtask
   task automatic lw(input logic [4:0] rd);
      set_in(1, 32'h100, 5'd2, 5'd0, rd, 3'd1, 1);
      step();
   endtask
   logic [2:0] tt [5] = '{3'd4, 3'd3, 3'd5, 3'd2, 3'd1};
   logic [4:0] t1 [5] = '{5'd5, 5'd1, 5'd5, 5'd5, 5'd3};
   logic [4:0] t2 [5] = '{5'd0, 5'd5, 5'd0, 5'd5, 5'd5};
   logic       ts [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
   initial begin
      bus.Branch_Taken = 0;
      bus.Ext_Stall    = 0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      chk_en = 1;
      chk("rst_state", 160'(bus.Hz_State), 160'(0));
      chk("rst_cnt", 160'({bus.Stall_Count, bus.Flush_Count}), 160'(0));
      chk("rst_valid", 160'(bus.ID_EX_Valid), 160'(0));
      rst = 0;
      // load-use on rs1
      lw(5);
      set_in(1, 32'h104, 5'd5, 5'd1, 5'd6, 3'd0, 0);
      #2 chk("lu_rs1_stall", 160'(bus.Stall_PC), 160'(1));
      step();
      chk("lu_bubble_rw", 160'(bus.ID_EX_RegWrite), 160'(0));
      chk("lu_stall_cnt", 160'(bus.Stall_Count), 160'(1));
      chk("lu_state", 160'(bus.Hz_State), 160'(1));
      step();
      chk("lu_add_enters", 160'(bus.ID_EX_RDes), 160'(6));
      // store exemption
      lw(5);
      set_in(1, 32'h108, 5'd2, 5'd5, 5'd0, 3'd2, 0);
      #2 chk("store_exempt", 160'(bus.Stall_PC), 160'(0));
      step();
      lw(5);
      set_in(1, 32'h10C, 5'd5, 5'd7, 5'd0, 3'd2, 0);
      #2 chk("store_addr_stall", 160'(bus.Stall_PC), 160'(1));
      step();
      step();
      chk("store_stall_cnt", 160'(bus.Stall_Count), 160'(2));
      // x0 and U ignored
      lw(0);
      set_in(1, 32'h110, 5'd0, 5'd0, 5'd1, 3'd0, 0);
      #2 chk("x0_no_stall", 160'(bus.Stall_PC), 160'(0));
      step();
      lw(5);
      set_in(1, 32'h114, 5'd5, 5'd5, 5'd5, 3'd6, 0);
      #2 chk("lui_no_stall", 160'(bus.Stall_PC), 160'(0));
      step();
      // branch beats load-use
      lw(5);
      set_in(1, 32'h118, 5'd5, 5'd1, 5'd6, 3'd0, 0);
      bus.Branch_Taken = 1;
      #2 chk("br_flush", 160'(bus.Flush_IF_ID), 160'(1));
      chk("br_no_stall", 160'(bus.Stall_PC), 160'(0));
      step();
      bus.Branch_Taken = 0;
      chk("br_flush_cnt", 160'(bus.Flush_Count), 160'(1));
      chk("br_stall_cnt", 160'(bus.Stall_Count), 160'(2));
      chk("br_state", 160'(bus.Hz_State), 160'(2));
      chk("br_bubble", 160'(bus.ID_EX_Valid), 160'(0));
      step();
      // Ext_Stall freezes with load-use and a pending branch present
      lw(5);
      set_in(1, 32'h11C, 5'd5, 5'd1, 5'd6, 3'd0, 0);
      bus.Ext_Stall    = 1;
      bus.Branch_Taken = 1;
      for (int i = 0; i < 3; i++) begin
         #2 chk("ext_stall_pc", 160'(bus.Stall_PC), 160'(1));
         chk("ext_no_flush", 160'(bus.Flush_IF_ID), 160'(0));
         step();
         chk("ext_hold_rd", 160'(bus.ID_EX_RDes), 160'(5));
         chk("ext_hold_cnt", 160'({bus.Stall_Count, bus.Flush_Count}), 160'({32'd2, 32'd1}));
      end
      bus.Ext_Stall    = 0;
      bus.Branch_Taken = 0;
      #2 chk("ext_release_stall", 160'(bus.Stall_PC), 160'(1));
      step();
      chk("ext_release_cnt", 160'(bus.Stall_Count), 160'(3));
      step();
      // operand-use table
      for (int i = 0; i < 5; i++) begin
         lw(5);
         set_in(1, 32'h200 + 32'(i * 4), t1[i], t2[i], 5'd9, tt[i], 0);
         #2 chk("use_table", 160'(bus.Stall_PC), 160'(ts[i]));
         step();
         step();
      end
      chk("table_stall_cnt", 160'(bus.Stall_Count), 160'(6));
      // reset during STALL
      lw(5);
      set_in(1, 32'h300, 5'd5, 5'd1, 5'd6, 3'd0, 0);
      step();
      chk("pre_rst_state", 160'(bus.Hz_State), 160'(1));
      rst = 1;
      step();
      chk("rst_mid_state", 160'(bus.Hz_State), 160'(0));
      chk("rst_mid_cnt", 160'({bus.Stall_Count, bus.Flush_Count}), 160'(0));
      chk("rst_mid_id_ex", 160'(out_vec()), 160'(0));
      chk("rst_mid_stall", 160'({bus.Stall_PC, bus.Stall_IF_ID, bus.Flush_IF_ID}), 160'(0));
      rst = 0;
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
